// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared types for the PCIe PHY clock/reset support blocks
package pcie_phy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    LOST
  } mon_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit double-flop synchronizer, async active-high reset to 0
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/refclk_activity_monitor.sv
// rtl/refclk_activity_monitor.sv - counts mon_clk_i rises per window and reports rate lock
module refclk_activity_monitor
  import pcie_phy_pkg::*;
#(
  parameter int WINDOW_CYCLES = 64,
  parameter int EXP_EDGES     = 16,
  parameter int TOL           = 1,
  parameter int LOCK_WINDOWS  = 2,
  localparam int CW           = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          mon_clk_i,
  output logic          locked_o,
  output logic          loss_o,
  output logic          meas_valid_o,
  output logic [CW-1:0] meas_count_o
);

  localparam int GW   = $clog2(LOCK_WINDOWS + 1);
  localparam int LO_I = (EXP_EDGES > TOL) ? EXP_EDGES - TOL : 0;
  localparam logic [CW:0]   LO     = (CW+1)'(LO_I);
  localparam logic [CW:0]   HI     = (CW+1)'(EXP_EDGES + TOL);
  localparam logic [CW-1:0] WEND   = CW'(WINDOW_CYCLES - 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_WINDOWS);

  mon_state_e    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] ecnt_q, ecnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] good_q, good_d;
  logic          edge_q, edge_d;
  logic          locked_q, locked_d;
  logic          loss_q, loss_d;
  logic          valid_q, valid_d;

  logic          mon_sync;
  logic          rise;
  logic [CW:0]   result;
  logic [CW-1:0] result_sat;
  logic          win_end;
  logic          in_range;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (mon_clk_i),
    .q_o   (mon_sync)
  );

  // A rise seen in the last window cycle is folded into that window's result.
  assign rise       = mon_sync & ~edge_q;
  assign result     = {1'b0, ecnt_q} + {{CW{1'b0}}, rise};
  assign result_sat = result[CW] ? {CW{1'b1}} : result[CW-1:0];
  assign win_end    = (state_q != IDLE) && (wcnt_q == WEND);
  assign in_range   = (result >= LO) && (result <= HI);

  always_comb begin
    edge_d  = mon_sync;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    good_d  = good_q;
    count_d = count_q;
    loss_d  = 1'b0;
    valid_d = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
      ecnt_d  = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
          wcnt_d  = '0;
          ecnt_d  = '0;
          good_d  = '0;
        end
        default: begin
          wcnt_d = win_end ? '0 : wcnt_q + CW'(1);
          ecnt_d = win_end ? '0 : result_sat;
          if (win_end) begin
            count_d = result_sat;
            valid_d = 1'b1;
          end
          case (state_q)
            MEASURE: begin
              if (win_end) begin
                if (in_range) begin
                  good_d = good_q + GW'(1);
                  if (good_d >= LOCK_N) state_d = LOCKED;
                end else begin
                  good_d = '0;
                end
              end
            end
            LOCKED: begin
              if (win_end && !in_range) begin
                state_d = LOST;
                loss_d  = 1'b1;
              end
            end
            LOST: begin
              state_d = MEASURE;
              good_d  = '0;
            end
            default: ;
          endcase
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      ecnt_q   <= '0;
      good_q   <= '0;
      count_q  <= '0;
      edge_q   <= 1'b0;
      locked_q <= 1'b0;
      loss_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ecnt_q   <= ecnt_d;
      good_q   <= good_d;
      count_q  <= count_d;
      edge_q   <= edge_d;
      locked_q <= locked_d;
      loss_q   <= loss_d;
      valid_q  <= valid_d;
    end
  end

  assign locked_o     = locked_q;
  assign loss_o       = loss_q;
  assign meas_valid_o = valid_q;
  assign meas_count_o = count_q;

endmodule

// File: tb/tb_refclk_activity_monitor.sv
// tb/tb_refclk_activity_monitor.sv - scoreboard bench for refclk_activity_monitor
module tb_refclk_activity_monitor;

  localparam int WIN   = 64;
  localparam int EXP   = 16;
  localparam int TOL   = 1;
  localparam int LOCKW = 2;
  localparam int CW    = 7;

  logic          clk_i     = 1'b0;
  logic          rst_i     = 1'b1;
  logic          enable_i  = 1'b0;
  logic          mon_clk_i = 1'b0;
  logic          locked_o;
  logic          loss_o;
  logic          meas_valid_o;
  logic [CW-1:0] meas_count_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  // reference model state: window position, edge tally, good-window run
  int m_pos = 0;
  int m_cnt = 0;
  int m_run = 0;
  bit m_act = 1'b0;
  bit m_locked = 1'b0;
  bit m_loss = 1'b0;
  bit m_valid = 1'b0;
  bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  bit mon_on = 1'b0;

  int gen_mode = 1;
  int gen_per  = 4;
  bit gen_lvl  = 1'b0;
  int ph       = 0;
  int hcnt     = 0;

  refclk_activity_monitor dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .mon_clk_i    (mon_clk_i),
    .locked_o     (locked_o),
    .loss_o       (loss_o),
    .meas_valid_o (meas_valid_o),
    .meas_count_o (meas_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: a rise driven before posedge k is usable two edges later; windows are WIN edges long.
  initial begin
    bit rise;
    bit inr;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        m_act = 1'b0; m_pos = 0; m_cnt = 0; m_run = 0;
        m_locked = 1'b0; m_loss = 1'b0; m_valid = 1'b0;
      end else begin
        rise = h2 & ~h3;
        m_loss = 1'b0;
        m_valid = 1'b0;
        if (!enable_i) begin
          m_act = 1'b0; m_pos = 0; m_cnt = 0; m_run = 0; m_locked = 1'b0;
        end else if (!m_act) begin
          m_act = 1'b1; m_pos = 0; m_cnt = 0; m_run = 0;
        end else begin
          m_cnt = m_cnt + int'(rise);
          if (m_pos == WIN - 1) begin
            inr = (m_cnt >= EXP - TOL) && (m_cnt <= EXP + TOL);
            if (m_locked) begin
              if (!inr) begin
                m_locked = 1'b0;
                m_loss = 1'b1;
                m_run = 0;
              end
            end else if (inr) begin
              m_run++;
              if (m_run >= LOCKW) m_locked = 1'b1;
            end else begin
              m_run = 0;
            end
            exp_q.push_back(m_cnt);
            m_valid = 1'b1;
            m_cnt = 0;
            m_pos = 0;
          end else begin
            m_pos++;
          end
        end
        h3 = h2;
        h2 = h1;
        h1 = mon_clk_i;
      end
    end
  end

  // Monitor: flag levels every cycle, window result popped from the scoreboard on meas_valid_o.
  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk_i);
      chk("locked_o", int'(locked_o), int'(m_locked));
      chk("loss_o", int'(loss_o), int'(m_loss));
      chk("meas_valid_o", int'(meas_valid_o), int'(m_valid));
      if (meas_valid_o) begin
        if (exp_q.size() == 0) bound_fail("meas_count_unexpected");
        else chk("meas_count_o", int'(meas_count_o), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    case (gen_mode)
      0: mon_clk_i = gen_lvl;
      1: begin
        ph++;
        mon_clk_i = ((ph % gen_per) < (gen_per / 2));
      end
      default: begin
        if (hcnt <= 0) begin
          mon_clk_i = ~mon_clk_i;
          hcnt = int'($urandom_range(1, 3));
        end
        hcnt--;
      end
    endcase
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_valid_o && n < 300);
    if (!meas_valid_o) bound_fail(name);
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (m_pos != p && n < 300) begin
      tick();
      n++;
    end
    if (m_pos != p) bound_fail("wait_pos");
  endtask

  // Remove or add whole period-4 slots in the middle of the current window.
  task automatic mod_window(input int skip, input int pairs);
    wait_pos(20);
    while ((ph % 4) != 3) tick();
    repeat (skip) begin
      @(negedge clk_i);
      mon_clk_i = 1'b0;
    end
    repeat (pairs) begin
      @(negedge clk_i);
      mon_clk_i = 1'b1;
      @(negedge clk_i);
      mon_clk_i = 1'b0;
    end
  endtask

  task automatic restart();
    enable_i = 1'b0;
    repeat (3) tick();
    enable_i = 1'b1;
  endtask

  initial begin
    int n;
    enable_i = 1'b1;
    repeat (2) tick();
    mon_on = 1'b1;
    tick();
    chk("reset_locked", int'(locked_o), 0);
    chk("reset_loss", int'(loss_o), 0);
    chk("reset_valid", int'(meas_valid_o), 0);
    chk("reset_count", int'(meas_count_o), 0);
    rst_i = 1'b0;

    // nominal lock at 16 edges per window
    wait_valid("lock_w1");
    chk("lock_w1_locked", int'(locked_o), 0);
    wait_valid("lock_w2");
    chk("lock_w2_locked", int'(locked_o), 1);
    chk("lock_w2_count", int'(meas_count_o), 16);

    // tolerance: 15 then 17 locks, 14 never does
    restart();
    mod_window(4, 0);
    wait_valid("tol15");
    chk("tol15_count", int'(meas_count_o), 15);
    chk("tol15_locked", int'(locked_o), 0);
    mod_window(0, 2);
    wait_valid("tol17");
    chk("tol17_count", int'(meas_count_o), 17);
    chk("tol17_locked", int'(locked_o), 1);
    restart();
    repeat (3) begin
      mod_window(8, 0);
      wait_valid("tol14");
      chk("tol14_count", int'(meas_count_o), 14);
      chk("tol14_locked", int'(locked_o), 0);
    end

    // loss: lock, then hold mon_clk_i low
    restart();
    wait_valid("loss_pre1");
    wait_valid("loss_pre2");
    chk("loss_pre_locked", int'(locked_o), 1);
    wait_pos(60);
    gen_mode = 0;
    gen_lvl = 1'b0;
    wait_valid("loss_partial");
    wait_valid("loss_window");
    chk("loss_count", int'(meas_count_o), 0);
    chk("loss_pulse", int'(loss_o), 1);
    chk("loss_locked", int'(locked_o), 0);
    tick();
    chk("loss_pulse_end", int'(loss_o), 0);
    gen_mode = 1;
    wait_valid("relock_w1");
    chk("relock_w1_locked", int'(locked_o), 0);
    wait_valid("relock_w2");
    chk("relock_w2_locked", int'(locked_o), 1);
    chk("relock_w2_count", int'(meas_count_o), 16);

    // mid-window disable while locked
    wait_pos(30);
    enable_i = 1'b0;
    tick();
    chk("dis_locked", int'(locked_o), 0);
    chk("dis_loss", int'(loss_o), 0);
    chk("dis_valid", int'(meas_valid_o), 0);
    repeat (3) tick();
    enable_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_valid_o && n < 300);
    chk("reen_latency", n, 65);
    chk("reen_count", int'(meas_count_o), 16);
    wait_valid("reen_w2");
    chk("reen_w2_locked", int'(locked_o), 1);

    // asynchronous reset between clock edges
    #2 rst_i = 1'b1;
    #1;
    chk("areset_locked", int'(locked_o), 0);
    chk("areset_count", int'(meas_count_o), 0);
    chk("areset_valid", int'(meas_valid_o), 0);
    chk("areset_loss", int'(loss_o), 0);
    #1 rst_i = 1'b0;
    wait_valid("areset_w1");
    chk("areset_w1_locked", int'(locked_o), 0);
    wait_valid("areset_w2");
    chk("areset_w2_locked", int'(locked_o), 1);

    // window-boundary rise: lands at the final cycle, then one cycle too late
    gen_mode = 0;
    gen_lvl = 1'b0;
    restart();
    wait_pos(61);
    gen_lvl = 1'b1;
    mon_clk_i = 1'b1;
    wait_valid("bnd_in");
    chk("bnd_in_count", int'(meas_count_o), 1);
    gen_lvl = 1'b0;
    mon_clk_i = 1'b0;
    wait_valid("bnd_in_next");
    chk("bnd_in_next_count", int'(meas_count_o), 0);
    wait_pos(62);
    gen_lvl = 1'b1;
    mon_clk_i = 1'b1;
    wait_valid("bnd_late");
    chk("bnd_late_count", int'(meas_count_o), 0);
    wait_valid("bnd_late_next");
    chk("bnd_late_next_count", int'(meas_count_o), 1);

    // randomized jitter with one random mid-window disable
    gen_mode = 2;
    repeat (16) wait_valid("rand_a");
    wait_pos(int'($urandom_range(1, 62)));
    restart();
    repeat (6) wait_valid("rand_b");

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
